// File: rtl/ibex_fetch_align_fifo_pkg.sv
// Shared types and helpers for the fetch alignment FIFO.
package ibex_fetch_align_fifo_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fifo_entry_t;

    // Where a fetch fault sits relative to the presented instruction.
    typedef enum logic [1:0] {
        FETCH_ERR_NONE  = 2'd0,
        FETCH_ERR_HEAD  = 2'd1,
        FETCH_ERR_PLUS2 = 2'd2
    } fetch_err_e;

    function automatic logic is_compressed(input logic [1:0] opcode_lsb);
        return opcode_lsb != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_fetch_align_fifo_if.sv
// Bus-response and IF-stage handshake bundle for the fetch alignment FIFO.
// out_valid/out_ready: an instruction transfers on a cycle where both are high;
// valid never depends on ready and the payload holds while valid && !ready (except on clear).
interface ibex_fetch_align_fifo_if;
    logic        clear_i;
    logic [31:0] in_addr_i;
    logic        in_valid_i;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        busy_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic [31:0] out_addr_next_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    modport slave (
        input  clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
        output busy_o, out_valid_o, out_rdata_o, out_addr_o, out_addr_next_o,
               out_err_o, out_err_plus2_o
    );

    modport master (
        output clear_i, in_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
        input  busy_o, out_valid_o, out_rdata_o, out_addr_o, out_addr_next_o,
               out_err_o, out_err_plus2_o
    );
endinterface

// File: rtl/ibex_fetch_align_fifo.sv
// Compacting word FIFO that realigns compressed and misaligned instructions for IF.
// An empty FIFO passes the incoming word straight through as the head.
module ibex_fetch_align_fifo
    import ibex_fetch_align_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ibex_fetch_align_fifo_if.slave bus
);

    localparam int unsigned DEPTH = NUM_REQS + 1;

    fifo_entry_t      entry_q [DEPTH];
    fifo_entry_t      entry_d [DEPTH];
    fifo_entry_t      in_entry;
    logic [DEPTH-1:0] valid_q, valid_d, valid_pushed, valid_popped, lowest_free, entry_en;
    logic [31:1]      instr_addr_q, instr_addr_d;

    logic        misaligned, head_avail, second_avail;
    logic [31:0] head_rdata, instr;
    logic [15:0] second_lo;
    logic        head_err, second_err, instr_comp;
    logic        out_valid, consume, pop;
    logic [31:0] addr_cur, addr_next;
    fetch_err_e  err_kind;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = bus.in_addr_i[0];
    assign in_entry        = '{rdata: bus.in_rdata_i, err: bus.in_err_i};

    assign misaligned   = instr_addr_q[1];
    assign head_rdata   = valid_q[0] ? entry_q[0].rdata : bus.in_rdata_i;
    assign head_err     = valid_q[0] ? entry_q[0].err   : bus.in_err_i;
    assign second_lo    = valid_q[1] ? entry_q[1].rdata[15:0] : bus.in_rdata_i[15:0];
    assign second_err   = valid_q[1] ? entry_q[1].err   : bus.in_err_i;
    assign head_avail   = valid_q[0] | bus.in_valid_i;
    assign second_avail = valid_q[1] | (valid_q[0] & bus.in_valid_i);

    assign instr      = misaligned ? {second_lo, head_rdata[31:16]} : head_rdata;
    assign instr_comp = is_compressed(instr[1:0]);

    // A misaligned head can go out alone if it faults or its upper half is a full instruction.
    assign out_valid = ~bus.clear_i & head_avail &
                       (~misaligned | head_err | instr_comp | second_avail);
    assign consume   = out_valid & bus.out_ready_i;
    // An aligned compressed instruction leaves the upper half in the head word.
    assign pop       = consume & (misaligned | ~instr_comp);

    always_comb begin
        err_kind = FETCH_ERR_NONE;
        if (out_valid) begin
            if (head_err) begin
                err_kind = FETCH_ERR_HEAD;
            end else if (misaligned & ~instr_comp & second_err) begin
                err_kind = FETCH_ERR_PLUS2;
            end
        end
    end

    assign addr_cur     = {instr_addr_q, 1'b0};
    assign addr_next    = addr_cur + ((out_valid & instr_comp) ? 32'd2 : 32'd4);
    assign instr_addr_d = bus.clear_i ? bus.in_addr_i[31:1] :
                          consume     ? addr_next[31:1]     : instr_addr_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i == 0) begin : g_head
            assign lowest_free[i] = ~valid_q[i];
        end else begin : g_tail
            assign lowest_free[i] = ~valid_q[i] & valid_q[i-1];
        end

        assign valid_pushed[i] = (bus.in_valid_i & lowest_free[i]) | valid_q[i];

        if (i < DEPTH - 1) begin : g_shift
            assign valid_popped[i] = pop ? valid_pushed[i+1] : valid_pushed[i];
            assign entry_en[i]     = (valid_pushed[i+1] & pop) |
                                     (bus.in_valid_i & lowest_free[i] & ~pop);
            assign entry_d[i]      = valid_q[i+1] ? entry_q[i+1] : in_entry;
        end else begin : g_last
            assign valid_popped[i] = ~pop & valid_pushed[i];
            assign entry_en[i]     = bus.in_valid_i & lowest_free[i] & ~pop;
            assign entry_d[i]      = in_entry;
        end

        assign valid_d[i] = ~bus.clear_i & valid_popped[i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            instr_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            instr_addr_q <= instr_addr_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_en[i]) begin
                    entry_q[i] <= entry_d[i];
                end
            end
        end
    end

    if (NUM_REQS >= 2) begin : g_busy
        assign bus.busy_o = valid_q[NUM_REQS-2];
    end else begin : g_busy_always
        assign bus.busy_o = 1'b1;
    end

    assign bus.out_valid_o     = out_valid;
    assign bus.out_rdata_o     = instr;
    assign bus.out_addr_o      = addr_cur;
    assign bus.out_addr_next_o = addr_next;
    assign bus.out_err_o       = err_kind != FETCH_ERR_NONE;
    assign bus.out_err_plus2_o = err_kind == FETCH_ERR_PLUS2;

    overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.in_valid_i & ~bus.clear_i & (&valid_q) & ~pop));

endmodule
